// File: rtl/tboom_rmt_pkg.sv
// Shared types for the rename-side checkpoint logic.
package tboom_rmt_pkg;

  localparam int CHECKPOINT_DEPTH = 8;
  localparam int TAG_W            = $clog2(CHECKPOINT_DEPTH);

  typedef logic [TAG_W-1:0]            tag_t;
  typedef logic [CHECKPOINT_DEPTH-1:0] br_mask_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    DRAIN   = 2'd2
  } ckpt_state_e;

endpackage

// File: rtl/tboom_prio_enc_lsb.sv
// Lowest-set-bit priority encoder with a valid flag.
module tboom_prio_enc_lsb #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/tboom_checkpoint_ctrl.sv
// Branch-checkpoint controller: allocates branch tags at rename, frees them on
// correct resolution and sequences a rename restore plus younger-slot kill on
// a mispredict.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | allocation and resolution accepted
// RESTORE | one cycle: rn_restore to rename unit, kill pulse out
// DRAIN   | RESTORE_BUBBLE stall cycles before allocation resumes
module tboom_checkpoint_ctrl
  import tboom_rmt_pkg::*;
#(
  parameter int CHECKPOINT_DEPTH = tboom_rmt_pkg::CHECKPOINT_DEPTH,
  parameter int TAG_W            = $clog2(CHECKPOINT_DEPTH),
  parameter int RESTORE_BUBBLE   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_req,
  output logic                        alloc_gnt,
  output logic [TAG_W-1:0]            alloc_tag,
  output logic [CHECKPOINT_DEPTH-1:0] alloc_br_mask,
  output logic [CHECKPOINT_DEPTH-1:0] live_mask,
  input  logic                        resolve_valid,
  input  logic [TAG_W-1:0]            resolve_tag,
  input  logic                        resolve_mispredict,
  output logic                        resolve_ready,
  output logic                        clear_valid,
  output logic [CHECKPOINT_DEPTH-1:0] clear_mask,
  output logic                        kill_valid,
  output logic [CHECKPOINT_DEPTH-1:0] kill_mask,
  output logic                        rn_checkpoint,
  output logic                        rn_restore,
  output logic [TAG_W-1:0]            rn_checkpoint_restore_pos,
  output logic                        stall
);

  localparam logic [2:0] BUBBLE_LOAD =
    (RESTORE_BUBBLE > 0) ? 3'(RESTORE_BUBBLE - 1) : 3'd0;

  ckpt_state_e                 state;
  logic [CHECKPOINT_DEPTH-1:0] older [CHECKPOINT_DEPTH];
  logic [2:0]                  bubble_cnt;
  logic [TAG_W-1:0]            pos_q;

  logic                        is_idle;
  logic                        any_free;
  logic                        res_hit;
  logic                        res_clr;
  logic                        res_mis;
  logic [CHECKPOINT_DEPTH-1:0] res_onehot;
  logic [CHECKPOINT_DEPTH-1:0] clr_bit;
  logic [CHECKPOINT_DEPTH-1:0] kill_set;
  logic [CHECKPOINT_DEPTH-1:0] alloc_onehot;

  tboom_prio_enc_lsb #(
    .WIDTH (CHECKPOINT_DEPTH),
    .IDX_W (TAG_W)
  ) u_free_enc (
    .req   (~live_mask),
    .idx   (alloc_tag),
    .valid (any_free)
  );

  // Decode resolution, allocation and the squash set for a mispredict.
  always_comb begin
    is_idle    = (state == IDLE);
    res_hit    = is_idle & resolve_valid & live_mask[resolve_tag];
    res_clr    = res_hit & ~resolve_mispredict;
    res_mis    = res_hit & resolve_mispredict;

    res_onehot              = '0;
    res_onehot[resolve_tag] = 1'b1;
    clr_bit                 = res_clr ? res_onehot : '0;

    // Younger slots are those that saw the resolved slot live when allocated.
    kill_set = res_onehot;
    for (int s = 0; s < CHECKPOINT_DEPTH; s++) begin
      if (live_mask[s] && older[s][resolve_tag]) kill_set[s] = 1'b1;
    end

    alloc_gnt     = alloc_req & is_idle & any_free &
                    ~(resolve_valid & resolve_mispredict);
    alloc_br_mask = live_mask & ~clr_bit;
    alloc_onehot  = '0;
    if (alloc_gnt) alloc_onehot[alloc_tag] = 1'b1;

    rn_checkpoint             = alloc_gnt;
    rn_checkpoint_restore_pos = is_idle ? alloc_tag : pos_q;
    resolve_ready             = is_idle;
    stall                     = ~is_idle | (alloc_req & ~alloc_gnt);
  end

  // State machine, slot bookkeeping and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      live_mask   <= '0;
      bubble_cnt  <= '0;
      pos_q       <= '0;
      clear_valid <= 1'b0;
      clear_mask  <= '0;
      kill_valid  <= 1'b0;
      kill_mask   <= '0;
      rn_restore  <= 1'b0;
      for (int s = 0; s < CHECKPOINT_DEPTH; s++) older[s] <= '0;
    end else begin
      clear_valid <= 1'b0;
      clear_mask  <= '0;
      kill_valid  <= 1'b0;
      kill_mask   <= '0;
      rn_restore  <= 1'b0;

      case (state)
        IDLE: begin
          live_mask <= (live_mask & ~clr_bit & ~(res_mis ? kill_set : '0))
                       | alloc_onehot;
          for (int s = 0; s < CHECKPOINT_DEPTH; s++) begin
            if (alloc_gnt && (TAG_W'(s) == alloc_tag))
              older[s] <= alloc_br_mask;
            else if (res_clr)
              older[s][resolve_tag] <= 1'b0;
          end
          if (res_clr) begin
            clear_valid <= 1'b1;
            clear_mask  <= res_onehot;
          end
          if (res_mis) begin
            pos_q      <= resolve_tag;
            kill_valid <= 1'b1;
            kill_mask  <= kill_set;
            rn_restore <= 1'b1;
            state      <= RESTORE;
          end
        end

        RESTORE: begin
          if (RESTORE_BUBBLE == 0) begin
            state <= IDLE;
          end else begin
            bubble_cnt <= BUBBLE_LOAD;
            state      <= DRAIN;
          end
        end

        DRAIN: begin
          if (bubble_cnt == 3'd0) state <= IDLE;
          else bubble_cnt <= bubble_cnt - 3'd1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tboom_checkpoint_ctrl.sv
// Self-checking bench for tboom_checkpoint_ctrl.
module tb_tboom_checkpoint_ctrl;

  localparam int D  = 8;
  localparam int TW = 3;
  localparam int RB = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_req;
  logic          alloc_gnt;
  logic [TW-1:0] alloc_tag;
  logic [D-1:0]  alloc_br_mask;
  logic [D-1:0]  live_mask;
  logic          resolve_valid;
  logic [TW-1:0] resolve_tag;
  logic          resolve_mispredict;
  logic          resolve_ready;
  logic          clear_valid;
  logic [D-1:0]  clear_mask;
  logic          kill_valid;
  logic [D-1:0]  kill_mask;
  logic          rn_checkpoint;
  logic          rn_restore;
  logic [TW-1:0] rn_checkpoint_restore_pos;
  logic          stall;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [D-1:0]  mask;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  tboom_checkpoint_ctrl #(
    .CHECKPOINT_DEPTH (D),
    .TAG_W            (TW),
    .RESTORE_BUBBLE   (RB)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .alloc_req                 (alloc_req),
    .alloc_gnt                 (alloc_gnt),
    .alloc_tag                 (alloc_tag),
    .alloc_br_mask             (alloc_br_mask),
    .live_mask                 (live_mask),
    .resolve_valid             (resolve_valid),
    .resolve_tag               (resolve_tag),
    .resolve_mispredict        (resolve_mispredict),
    .resolve_ready             (resolve_ready),
    .clear_valid               (clear_valid),
    .clear_mask                (clear_mask),
    .kill_valid                (kill_valid),
    .kill_mask                 (kill_mask),
    .rn_checkpoint             (rn_checkpoint),
    .rn_restore                (rn_restore),
    .rn_checkpoint_restore_pos (rn_checkpoint_restore_pos),
    .stall                     (stall)
  );

  always #5 clk = ~clk;

  // Scoreboard: every grant must match the oldest expected grant.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (rn_checkpoint && rn_restore) begin
        failures++;
        $display("FAIL ckpt_and_restore both high at %0t", $time);
      end
      if (alloc_gnt) begin
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_grant tag=%0d", alloc_tag);
        end else begin
          e = sb.pop_front();
          if (alloc_tag !== e.tag || alloc_br_mask !== e.mask ||
              rn_checkpoint_restore_pos !== e.tag || rn_checkpoint !== 1'b1) begin
            failures++;
            $display("FAIL grant got tag=%0d mask=%h pos=%0d ckpt=%b want tag=%0d mask=%h",
                     alloc_tag, alloc_br_mask, rn_checkpoint_restore_pos,
                     rn_checkpoint, e.tag, e.mask);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req          = 1'b0;
    resolve_valid      = 1'b0;
    resolve_tag        = '0;
    resolve_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_req = 1'b1;
      sb.push_back('{tag: TW'(i), mask: D'((1 << i) - 1)});
      tick();
    end
    alloc_req = 1'b0;
  endtask

  task automatic sb_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s missing_grants=%0d want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (live_mask !== 8'h00 || stall !== 1'b0 || clear_valid !== 1'b0 ||
        kill_valid !== 1'b0 || rn_restore !== 1'b0 || resolve_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset live=%h stall=%b clr=%b kill=%b rst=%b rdy=%b want 00 0 0 0 0 1",
               live_mask, stall, clear_valid, kill_valid, rn_restore, resolve_ready);
    end
  endtask

  task automatic test_alloc_seq();
    do_reset();
    alloc_n(3);
    @(negedge clk);
    checks++;
    if (live_mask !== 8'h07) begin
      failures++;
      $display("FAIL alloc_seq live=%h want 07", live_mask);
    end
    sb_drained("alloc_seq");
  endtask

  task automatic test_full_and_free();
    do_reset();
    alloc_n(8);
    alloc_req = 1'b1;
    @(negedge clk);
    checks++;
    if (alloc_gnt !== 1'b0 || stall !== 1'b1 || live_mask !== 8'hFF) begin
      failures++;
      $display("FAIL full gnt=%b stall=%b live=%h want 0 1 ff", alloc_gnt, stall, live_mask);
    end
    tick();
    resolve_valid = 1'b1;
    resolve_tag   = 3'd5;
    @(negedge clk);
    checks++;
    if (alloc_gnt !== 1'b0) begin
      failures++;
      $display("FAIL free_same_cycle gnt=%b want 0", alloc_gnt);
    end
    tick();
    resolve_valid = 1'b0;
    sb.push_back('{tag: 3'd5, mask: 8'hDF});
    @(negedge clk);
    checks++;
    if (clear_valid !== 1'b1 || clear_mask !== 8'h20) begin
      failures++;
      $display("FAIL clear_pulse valid=%b mask=%h want 1 20", clear_valid, clear_mask);
    end
    tick();
    alloc_req = 1'b0;
    @(negedge clk);
    checks++;
    if (live_mask !== 8'hFF || clear_valid !== 1'b0) begin
      failures++;
      $display("FAIL refill live=%h clr=%b want ff 0", live_mask, clear_valid);
    end
    sb_drained("full_and_free");
  endtask

  task automatic test_alloc_with_clear();
    do_reset();
    alloc_n(4);
    alloc_req     = 1'b1;
    resolve_valid = 1'b1;
    resolve_tag   = 3'd1;
    sb.push_back('{tag: 3'd4, mask: 8'h0D});
    tick();
    resolve_valid = 1'b0;
    sb.push_back('{tag: 3'd1, mask: 8'h1D});
    @(negedge clk);
    checks++;
    if (clear_valid !== 1'b1 || clear_mask !== 8'h02) begin
      failures++;
      $display("FAIL alloc_clear_pulse valid=%b mask=%h want 1 02", clear_valid, clear_mask);
    end
    tick();
    alloc_req = 1'b0;
    @(negedge clk);
    checks++;
    if (live_mask !== 8'h1F) begin
      failures++;
      $display("FAIL alloc_clear live=%h want 1f", live_mask);
    end
    // Slot 4 must not count re-allocated slot 1 as older than itself.
    resolve_valid      = 1'b1;
    resolve_tag        = 3'd1;
    resolve_mispredict = 1'b1;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (kill_valid !== 1'b1 || kill_mask !== 8'h02 || live_mask !== 8'h1D) begin
      failures++;
      $display("FAIL older_excl kill=%b mask=%h live=%h want 1 02 1d",
               kill_valid, kill_mask, live_mask);
    end
    for (int c = 0; c < RB + 1; c++) tick();
    sb_drained("alloc_with_clear");
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc_n(5);
    resolve_valid      = 1'b1;
    resolve_tag        = 3'd2;
    resolve_mispredict = 1'b1;
    tick();
    idle_inputs();
    alloc_req = 1'b1;
    for (int c = 0; c < RB + 1; c++) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || resolve_ready !== 1'b0 || rn_checkpoint !== 1'b0) begin
        failures++;
        $display("FAIL restore_stall c=%0d stall=%b rdy=%b ckpt=%b want 1 0 0",
                 c, stall, resolve_ready, rn_checkpoint);
      end
      checks++;
      if (c == 0) begin
        if (rn_restore !== 1'b1 || rn_checkpoint_restore_pos !== 3'd2 ||
            kill_valid !== 1'b1 || kill_mask !== 8'h1C || live_mask !== 8'h03) begin
          failures++;
          $display("FAIL restore rst=%b pos=%0d kill=%b mask=%h live=%h want 1 2 1 1c 03",
                   rn_restore, rn_checkpoint_restore_pos, kill_valid, kill_mask, live_mask);
        end
      end else if (rn_restore !== 1'b0 || kill_valid !== 1'b0) begin
        failures++;
        $display("FAIL drain_pulses rst=%b kill=%b want 0 0", rn_restore, kill_valid);
      end
      tick();
    end
    sb.push_back('{tag: 3'd2, mask: 8'h03});
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || resolve_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_restore stall=%b rdy=%b want 0 1", stall, resolve_ready);
    end
    tick();
    alloc_req = 1'b0;
    sb_drained("mispredict");
  endtask

  task automatic test_nonlive();
    do_reset();
    alloc_n(3);
    resolve_valid      = 1'b1;
    resolve_tag        = 3'd3;
    resolve_mispredict = 1'b1;
    tick();
    resolve_tag        = 3'd6;
    resolve_mispredict = 1'b0;
    @(negedge clk);
    checks++;
    if (kill_valid !== 1'b0 || rn_restore !== 1'b0 || stall !== 1'b0 ||
        resolve_ready !== 1'b1 || live_mask !== 8'h07) begin
      failures++;
      $display("FAIL nonlive_mis kill=%b rst=%b stall=%b rdy=%b live=%h want 0 0 0 1 07",
               kill_valid, rn_restore, stall, resolve_ready, live_mask);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (clear_valid !== 1'b0 || live_mask !== 8'h07) begin
      failures++;
      $display("FAIL nonlive_clr clr=%b live=%h want 0 07", clear_valid, live_mask);
    end
    sb_drained("nonlive");
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    alloc_n(3);
    resolve_valid      = 1'b1;
    resolve_tag        = 3'd1;
    resolve_mispredict = 1'b1;
    tick();
    idle_inputs();
    tick();
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || live_mask !== 8'h01 || rn_restore !== 1'b0) begin
      failures++;
      $display("FAIL drain_state stall=%b live=%h rst=%b want 1 01 0",
               stall, live_mask, rn_restore);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    alloc_req = 1'b1;
    sb.push_back('{tag: 3'd0, mask: 8'h00});
    @(negedge clk);
    checks++;
    if (live_mask !== 8'h00 || stall !== 1'b0 || clear_valid !== 1'b0 ||
        kill_valid !== 1'b0 || rn_restore !== 1'b0 || resolve_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_drain live=%h stall=%b clr=%b kill=%b rst=%b rdy=%b",
               live_mask, stall, clear_valid, kill_valid, rn_restore, resolve_ready);
    end
    tick();
    alloc_req = 1'b0;
    sb_drained("reset_in_drain");
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_alloc_seq();
    test_full_and_free();
    test_alloc_with_clear();
    test_mispredict();
    test_nonlive();
    test_reset_in_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
